// File: rtl/ex_stage_pkg.sv
// Shared opcode, result-class and reset constants for the execute stage.
// Imported by ex_stage and hilo_reg.
package ex_stage_pkg;

    localparam int ALUOP_W  = 8;
    localparam int ALUSEL_W = 3;

    localparam logic       RST_ENABLE   = 1'b1;
    localparam logic       WRITE_ENABLE = 1'b1;
    localparam logic [4:0] NOP_REG_ADDR = 5'b00000;

    typedef enum logic [ALUOP_W-1:0] {
        EXE_NOP_OP  = 8'h00,
        EXE_MOVZ_OP = 8'h0A,
        EXE_MOVN_OP = 8'h0B,
        EXE_MFHI_OP = 8'h10,
        EXE_MTHI_OP = 8'h11,
        EXE_MFLO_OP = 8'h12,
        EXE_MTLO_OP = 8'h13,
        EXE_AND_OP  = 8'h24,
        EXE_OR_OP   = 8'h25,
        EXE_XOR_OP  = 8'h26,
        EXE_NOR_OP  = 8'h27
    } aluop_e;

    typedef enum logic [ALUSEL_W-1:0] {
        EXE_RES_NOP   = 3'b000,
        EXE_RES_LOGIC = 3'b001,
        EXE_RES_MOVE  = 3'b011
    } alusel_e;

    function automatic logic is_hilo_commit(input logic stall,
                                            input logic flush);
        return !stall && !flush;
    endfunction

endpackage

// File: rtl/hilo_reg.sv
// Architectural HI/LO register pair with independent write enables
// sharing one data port.
module hilo_reg
    import ex_stage_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] HILO_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_hi,
    input  logic              we_lo,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] hi_d, hi_q;
    logic [DATA_W-1:0] lo_d, lo_q;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (we_hi) hi_d = data;
        if (we_lo) lo_d = data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            hi_q <= HILO_RST;
            lo_q <= HILO_RST;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: logic/move ALU, combinational forward to ID,
// EX/MEM pipeline register and HI/LO ownership.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 5,
    parameter logic [DATA_W-1:0] HILO_RST = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ALUOP_W-1:0]  id_aluop,
    input  logic [ALUSEL_W-1:0] id_alusel,
    input  logic [DATA_W-1:0]   id_reg1,
    input  logic [DATA_W-1:0]   id_reg2,
    input  logic [ADDR_W-1:0]   id_waddr,
    input  logic                id_wr_en,
    input  logic                stall,
    input  logic                flush,
    output logic                ex_wr_en,
    output logic [ADDR_W-1:0]   ex_waddr,
    output logic [DATA_W-1:0]   ex_wdata,
    output logic                mem_wr_en,
    output logic [ADDR_W-1:0]   mem_waddr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o
);

    localparam logic [ADDR_W-1:0] NOP_ADDR = ADDR_W'(NOP_REG_ADDR);

    logic [DATA_W-1:0] hi, lo;
    logic [DATA_W-1:0] logic_res, move_res, result;
    logic              commit, we_hi, we_lo;

    always_comb begin
        logic_res = '0;
        unique case (id_aluop)
            EXE_OR_OP:  logic_res = id_reg1 | id_reg2;
            EXE_AND_OP: logic_res = id_reg1 & id_reg2;
            EXE_XOR_OP: logic_res = id_reg1 ^ id_reg2;
            EXE_NOR_OP: logic_res = ~(id_reg1 | id_reg2);
            default:    logic_res = '0;
        endcase
    end

    // HI/LO are read straight from the committed registers, so an
    // MFHI right after an MTHI already sees the new value.
    always_comb begin
        move_res = '0;
        unique case (id_aluop)
            EXE_MFHI_OP: move_res = hi;
            EXE_MFLO_OP: move_res = lo;
            EXE_MOVN_OP: move_res = id_reg1;
            EXE_MOVZ_OP: move_res = id_reg1;
            default:     move_res = '0;
        endcase
    end

    always_comb begin
        result = '0;
        unique case (id_alusel)
            EXE_RES_LOGIC: result = logic_res;
            EXE_RES_MOVE:  result = move_res;
            default:       result = '0;
        endcase
    end

    assign ex_wr_en = (rst == RST_ENABLE) ? 1'b0     : id_wr_en;
    assign ex_waddr = (rst == RST_ENABLE) ? NOP_ADDR : id_waddr;
    assign ex_wdata = (rst == RST_ENABLE) ? '0       : result;

    assign commit = is_hilo_commit(stall, flush) && (rst != RST_ENABLE);
    assign we_hi  = commit && (id_aluop == EXE_MTHI_OP);
    assign we_lo  = commit && (id_aluop == EXE_MTLO_OP);

    hilo_reg #(
        .DATA_W   (DATA_W),
        .HILO_RST (HILO_RST)
    ) u_hilo (
        .clk   (clk),
        .rst   (rst),
        .we_hi (we_hi),
        .we_lo (we_lo),
        .data  (id_reg1),
        .hi_o  (hi),
        .lo_o  (lo)
    );

    assign hi_o = hi;
    assign lo_o = lo;

    logic              mem_wr_en_d, mem_wr_en_q;
    logic [ADDR_W-1:0] mem_waddr_d, mem_waddr_q;
    logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;

    always_comb begin
        mem_wr_en_d = mem_wr_en_q;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        if (flush) begin
            mem_wr_en_d = 1'b0;
            mem_waddr_d = NOP_ADDR;
            mem_wdata_d = '0;
        end else if (!stall) begin
            mem_wr_en_d = ex_wr_en;
            mem_waddr_d = ex_waddr;
            mem_wdata_d = ex_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            mem_wr_en_q <= 1'b0;
            mem_waddr_q <= NOP_ADDR;
            mem_wdata_q <= '0;
        end else begin
            mem_wr_en_q <= mem_wr_en_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_wr_en = mem_wr_en_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: reference model checked every negedge plus
// hand-computed literal checks along the directed sequence.
module tb_ex_stage;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_MOVZ = 8'h0A;
    localparam logic [7:0] OP_MOVN = 8'h0B;
    localparam logic [7:0] OP_MFHI = 8'h10;
    localparam logic [7:0] OP_MTHI = 8'h11;
    localparam logic [7:0] OP_MFLO = 8'h12;
    localparam logic [7:0] OP_MTLO = 8'h13;
    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [2:0] SEL_NOP = 3'b000;
    localparam logic [2:0] SEL_LOG = 3'b001;
    localparam logic [2:0] SEL_MOV = 3'b011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  id_aluop = '0;
    logic [2:0]  id_alusel = '0;
    logic [31:0] id_reg1 = '0;
    logic [31:0] id_reg2 = '0;
    logic [4:0]  id_waddr = '0;
    logic        id_wr_en = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        ex_wr_en, mem_wr_en;
    logic [4:0]  ex_waddr, mem_waddr;
    logic [31:0] ex_wdata, mem_wdata, hi_o, lo_o;

    int n_cmp = 0;
    int n_bad = 0;

    ex_stage dut (
        .clk       (clk),
        .rst       (rst),
        .id_aluop  (id_aluop),
        .id_alusel (id_alusel),
        .id_reg1   (id_reg1),
        .id_reg2   (id_reg2),
        .id_waddr  (id_waddr),
        .id_wr_en  (id_wr_en),
        .stall     (stall),
        .flush     (flush),
        .ex_wr_en  (ex_wr_en),
        .ex_waddr  (ex_waddr),
        .ex_wdata  (ex_wdata),
        .mem_wr_en (mem_wr_en),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, want %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] model_result(
        input logic [7:0] op, input logic [2:0] sel,
        input logic [31:0] a, input logic [31:0] b,
        input logic [31:0] h, input logic [31:0] l);
        if (sel == SEL_LOG) begin
            if (op == OP_OR)  return a | b;
            if (op == OP_AND) return a & b;
            if (op == OP_XOR) return a ^ b;
            if (op == OP_NOR) return ~(a | b);
            return 32'h0;
        end
        if (sel == SEL_MOV) begin
            if (op == OP_MFHI) return h;
            if (op == OP_MFLO) return l;
            if (op == OP_MOVN || op == OP_MOVZ) return a;
            return 32'h0;
        end
        return 32'h0;
    endfunction

    logic [31:0] m_hi, m_lo, m_wdata;
    logic [4:0]  m_waddr;
    logic        m_wr_en;

    always @(posedge clk or posedge rst) begin
        logic [31:0] r;
        if (rst) begin
            m_hi = 32'h0; m_lo = 32'h0;
            m_wdata = 32'h0; m_waddr = 5'h0; m_wr_en = 1'b0;
        end else begin
            r = model_result(id_aluop, id_alusel, id_reg1, id_reg2,
                             m_hi, m_lo);
            if (flush) begin
                m_wdata = 32'h0; m_waddr = 5'h0; m_wr_en = 1'b0;
            end else if (!stall) begin
                m_wdata = r; m_waddr = id_waddr; m_wr_en = id_wr_en;
                if (id_aluop == OP_MTHI) m_hi = id_reg1;
                if (id_aluop == OP_MTLO) m_lo = id_reg1;
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        e = rst ? 32'h0 : model_result(id_aluop, id_alusel, id_reg1,
                                       id_reg2, m_hi, m_lo);
        chk("m_ex_wdata", ex_wdata, e);
        chk("m_ex_wr_en", 32'(ex_wr_en), rst ? 32'h0 : 32'(id_wr_en));
        chk("m_ex_waddr", 32'(ex_waddr), rst ? 32'h0 : 32'(id_waddr));
        chk("m_mem_wdata", mem_wdata, m_wdata);
        chk("m_mem_waddr", 32'(mem_waddr), 32'(m_waddr));
        chk("m_mem_wr_en", 32'(mem_wr_en), 32'(m_wr_en));
        chk("m_hi", hi_o, m_hi);
        chk("m_lo", lo_o, m_lo);
    end

    task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [4:0] wa, input logic we,
                         input logic st, input logic fl);
        @(posedge clk);
        #1;
        id_aluop = op; id_alusel = sel; id_reg1 = r1; id_reg2 = r2;
        id_waddr = wa; id_wr_en = we; stall = st; flush = fl;
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_mem_wr_en", 32'(mem_wr_en), 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_hi", hi_o, 32'h0);
        chk("rst_lo", lo_o, 32'h0);

        drive(OP_OR, SEL_LOG, 32'h0101_0000, 32'h0000_1100, 5'd1, 1, 0, 0);
        chk("or_ex", ex_wdata, 32'h0101_1100);
        drive(OP_AND, SEL_LOG, 32'h0101_0000, 32'h0000_1100, 5'd2, 1, 0, 0);
        chk("or_mem", mem_wdata, 32'h0101_1100);
        chk("or_mem_waddr", 32'(mem_waddr), 32'd1);
        chk("and_ex", ex_wdata, 32'h0);
        drive(OP_XOR, SEL_LOG, 32'h0101_0000, 32'h0000_1100, 5'd3, 1, 0, 0);
        chk("and_mem", mem_wdata, 32'h0);
        chk("xor_ex", ex_wdata, 32'h0101_1100);
        drive(OP_NOR, SEL_LOG, 32'h0101_0000, 32'h0000_1100, 5'd4, 1, 0, 0);
        chk("nor_ex", ex_wdata, 32'hFEFE_EEFF);

        drive(OP_MTHI, SEL_NOP, 32'hDEAD_BEEF, 32'h0, 5'd0, 0, 0, 0);
        chk("nor_mem", mem_wdata, 32'hFEFE_EEFF);
        chk("hi_before", hi_o, 32'h0);
        drive(OP_MFHI, SEL_MOV, 32'h0, 32'h0, 5'd4, 1, 0, 0);
        chk("mthi_hi", hi_o, 32'hDEAD_BEEF);
        chk("mfhi_ex", ex_wdata, 32'hDEAD_BEEF);
        drive(OP_MTLO, SEL_NOP, 32'h0000_00A5, 32'h0, 5'd0, 0, 0, 0);
        chk("mfhi_mem", mem_wdata, 32'hDEAD_BEEF);
        drive(OP_MFLO, SEL_MOV, 32'h0, 32'h0, 5'd5, 1, 0, 0);
        chk("mtlo_lo", lo_o, 32'h0000_00A5);
        chk("mflo_ex", ex_wdata, 32'h0000_00A5);

        repeat (3) drive(OP_MTHI, SEL_NOP, 32'h5, 32'h0, 5'd0, 0, 1, 0);
        chk("stall_hi", hi_o, 32'hDEAD_BEEF);
        chk("stall_mem", mem_wdata, 32'h0000_00A5);
        chk("stall_waddr", 32'(mem_waddr), 32'd5);
        drive(OP_MTHI, SEL_NOP, 32'h5, 32'h0, 5'd0, 0, 0, 0);
        chk("stall_hi2", hi_o, 32'hDEAD_BEEF);
        drive(OP_NOP, SEL_NOP, 32'h0, 32'h0, 5'd0, 0, 0, 0);
        chk("unstall_hi", hi_o, 32'h5);
        chk("unstall_wr_en", 32'(mem_wr_en), 32'h0);

        drive(OP_MFLO, SEL_MOV, 32'h0, 32'h0, 5'd7, 1, 0, 0);
        drive(OP_MTLO, SEL_NOP, 32'h7, 32'h0, 5'd0, 0, 1, 1);
        chk("pre_flush_mem", mem_wdata, 32'h0000_00A5);
        drive(OP_NOP, SEL_NOP, 32'h0, 32'h0, 5'd0, 0, 0, 0);
        chk("flush_wr_en", 32'(mem_wr_en), 32'h0);
        chk("flush_wdata", mem_wdata, 32'h0);
        chk("flush_lo", lo_o, 32'h0000_00A5);

        drive(OP_MOVN, SEL_MOV, 32'h0000_CAFE, 32'h0, 5'd6, 1, 0, 0);
        chk("movn_ex", ex_wdata, 32'h0000_CAFE);
        drive(OP_OR, 3'b111, 32'hFFFF, 32'h1, 5'd6, 1, 0, 0);
        chk("movn_mem", mem_wdata, 32'h0000_CAFE);
        chk("movn_wr_en", 32'(mem_wr_en), 32'h1);
        chk("badsel_ex", ex_wdata, 32'h0);

        drive(OP_OR, SEL_LOG, 32'h1234, 32'h0, 5'd8, 1, 0, 0);
        drive(OP_OR, SEL_LOG, 32'h1, 32'h2, 5'd9, 1, 0, 0);
        chk("pre_rst_mem", mem_wdata, 32'h1234);
        chk("pre_rst_ex", ex_wdata, 32'h3);
        rst = 1'b1;
        #1;
        chk("async_mem", mem_wdata, 32'h0);
        chk("async_hi", hi_o, 32'h0);
        chk("async_lo", lo_o, 32'h0);
        chk("async_ex_wr", 32'(ex_wr_en), 32'h0);
        chk("async_ex_wd", ex_wdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_mem", mem_wdata, 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule
